// File: rtl/trigger_pkg.sv
// Shared types and helpers for the multi-stage trigger sequencer.
package trigger_pkg;

    localparam int unsigned DefStn = 4;
    localparam int unsigned DefCnw = 16;

    typedef enum logic [2:0] {
        StIdle,
        StMatch,
        StDelay,
        StFire,
        StDone
    } seq_state_e;

    // LSB position of a stage's occurrence count inside the packed cfg_cnt vector.
    function automatic int unsigned stage_lsb(input int unsigned stage, input int unsigned cnw);
        return stage * cnw;
    endfunction

endpackage

// File: rtl/trigger_sequencer.sv
// Sequences per-stage matcher events into a single capture trigger pulse,
// with an optional post-trigger delay counted in qualified transfers.
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int unsigned STN = DefStn,
    parameter int unsigned CNW = DefCnw,
    localparam int unsigned SNW = $clog2(STN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctl_arm,
    input  logic               ctl_abort,
    input  logic [SNW-1:0]     cfg_last,
    input  logic [STN*CNW-1:0] cfg_cnt,
    input  logic [CNW-1:0]     cfg_dly,
    input  logic               sti_transfer,
    input  logic [STN-1:0]     evt_in,
    output logic               sts_armed,
    output logic [SNW-1:0]     sts_stage,
    output logic               sts_trg,
    output logic               sts_run
);

    seq_state_e     state;
    logic [CNW-1:0] cnt;
    logic [SNW-1:0] stage;
    logic           evt_vld;
    logic [SNW-1:0] last_stage;
    logic [CNW-1:0] stage_target;

    // Clamp out-of-range final stage and select the current stage's hit target.
    always_comb begin
        last_stage = cfg_last;
        if (cfg_last > SNW'(STN - 1)) begin
            last_stage = SNW'(STN - 1);
        end
        stage_target = cfg_cnt[stage_lsb(32'(stage), CNW) +: CNW];
    end

    assign sts_stage = stage;

    // Sequencer FSM; status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= '0;
            stage     <= '0;
            evt_vld   <= 1'b0;
            sts_armed <= 1'b0;
            sts_trg   <= 1'b0;
            sts_run   <= 1'b0;
        end else begin
            // Matcher events lag their transfer by one cycle; align the qualifier.
            evt_vld <= sti_transfer;
            sts_trg <= 1'b0;
            if (ctl_abort) begin
                state     <= StIdle;
                cnt       <= '0;
                stage     <= '0;
                sts_armed <= 1'b0;
                sts_run   <= 1'b0;
            end else if (ctl_arm) begin
                state     <= StMatch;
                cnt       <= '0;
                stage     <= '0;
                sts_armed <= 1'b1;
                sts_run   <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                    end
                    StMatch: begin
                        if (evt_vld && evt_in[stage]) begin
                            if (cnt != stage_target) begin
                                cnt <= cnt + CNW'(1);
                            end else if (stage < last_stage) begin
                                stage <= stage + SNW'(1);
                                cnt   <= '0;
                            end else begin
                                cnt <= '0;
                                if (cfg_dly == '0) begin
                                    state     <= StFire;
                                    sts_trg   <= 1'b1;
                                    sts_armed <= 1'b0;
                                    sts_run   <= 1'b1;
                                end else begin
                                    state <= StDelay;
                                end
                            end
                        end
                    end
                    StDelay: begin
                        if (evt_vld) begin
                            if (cnt == cfg_dly - CNW'(1)) begin
                                state     <= StFire;
                                cnt       <= '0;
                                sts_trg   <= 1'b1;
                                sts_armed <= 1'b0;
                                sts_run   <= 1'b1;
                            end else begin
                                cnt <= cnt + CNW'(1);
                            end
                        end
                    end
                    StFire: begin
                        state <= StDone;
                    end
                    StDone: begin
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_trigger_sequencer;

    localparam int STN = 4;
    localparam int CNW = 16;
    localparam int SNW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               ctl_arm;
    logic               ctl_abort;
    logic [SNW-1:0]     cfg_last;
    logic [STN*CNW-1:0] cfg_cnt;
    logic [CNW-1:0]     cfg_dly;
    logic               sti_transfer;
    logic [STN-1:0]     evt_in;
    logic               sts_armed;
    logic [SNW-1:0]     sts_stage;
    logic               sts_trg;
    logic               sts_run;

    always #5 clk = ~clk;

    trigger_sequencer #(.STN(STN), .CNW(CNW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctl_arm      (ctl_arm),
        .ctl_abort    (ctl_abort),
        .cfg_last     (cfg_last),
        .cfg_cnt      (cfg_cnt),
        .cfg_dly      (cfg_dly),
        .sti_transfer (sti_transfer),
        .evt_in       (evt_in),
        .sts_armed    (sts_armed),
        .sts_stage    (sts_stage),
        .sts_trg      (sts_trg),
        .sts_run      (sts_run)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Matcher stand-in: a hit presented with a transfer shows up on evt_in next cycle.
    logic [STN-1:0] pend;

    // Behavioural model: phase 0 idle, 1 matching, 2 delaying, 3 firing, 4 done.
    int m_phase, m_stage, m_hits, m_dly, m_last, m_delay_len;
    int m_need[STN];
    bit m_vld;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int pack(input bit armed, input int stage, input bit trg, input bit run);
        return {28'd0, armed, stage[1:0], trg} * 2 + int'(run);
    endfunction

    function automatic int dut_status();
        return pack(sts_armed, int'(sts_stage), sts_trg, sts_run);
    endfunction

    function automatic int model_status();
        return pack(m_phase == 1 || m_phase == 2, m_stage, m_phase == 3,
                    m_phase == 3 || m_phase == 4);
    endfunction

    task automatic set_cfg(input int last, input int c0, input int c1, input int c2,
                           input int c3, input int dly);
        cfg_last    = SNW'(last);
        cfg_cnt     = {CNW'(c3), CNW'(c2), CNW'(c1), CNW'(c0)};
        cfg_dly     = CNW'(dly);
        m_last      = (last > STN - 1) ? STN - 1 : last;
        m_need[0]   = c0 + 1;
        m_need[1]   = c1 + 1;
        m_need[2]   = c2 + 1;
        m_need[3]   = c3 + 1;
        m_delay_len = dly;
    endtask

    task automatic model_edge(input bit arm, input bit abort, input bit xfer,
                              input logic [STN-1:0] evt);
        if (abort) begin
            m_phase = 0;
            m_stage = 0;
        end else if (arm) begin
            m_phase = 1;
            m_stage = 0;
            m_hits  = 0;
        end else if (m_phase == 1) begin
            if (m_vld && evt[m_stage]) begin
                m_hits++;
                if (m_hits == m_need[m_stage]) begin
                    m_hits = 0;
                    if (m_stage < m_last) m_stage++;
                    else if (m_delay_len == 0) m_phase = 3;
                    else begin
                        m_phase = 2;
                        m_dly   = 0;
                    end
                end
            end
        end else if (m_phase == 2) begin
            if (m_vld) begin
                m_dly++;
                if (m_dly == m_delay_len) m_phase = 3;
            end
        end else if (m_phase == 3) begin
            m_phase = 4;
        end
        m_vld = xfer;
    endtask

    task automatic step(input bit arm, input bit abort, input bit xfer,
                        input logic [STN-1:0] hit);
        ctl_arm      = arm;
        ctl_abort    = abort;
        sti_transfer = xfer;
        evt_in       = pend;
        @(posedge clk);
        model_edge(arm, abort, xfer, pend);
        pend = xfer ? hit : '0;
        #1;
        ctl_arm   = 1'b0;
        ctl_abort = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        ctl_arm      = 1'b0;
        ctl_abort    = 1'b0;
        sti_transfer = 1'b0;
        evt_in       = '0;
        @(posedge clk);
        m_phase = 0;
        m_stage = 0;
        m_hits  = 0;
        m_dly   = 0;
        m_vld   = 1'b0;
        pend    = '0;
        #1;
        rst = 1'b1;
    endtask

    // Hit transfer followed by an idle cycle, so the hit is consumed before returning.
    task automatic hit_pair(input logic [STN-1:0] hit);
        step(1'b0, 1'b0, 1'b1, hit);
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    typedef struct {
        bit             arm;
        bit             abort;
        bit             xfer;
        logic [STN-1:0] hit;
        bit             e_armed;
        int             e_stage;
        bit             e_trg;
        bit             e_run;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int trg_at;
        int trg_cnt;
        int hit_stage[8];
        int exp_stage[8];

        do_reset();
        check("reset_status", dut_status(), 0);

        // Single stage, no occurrence count, no delay: trigger 2 cycles after the hit transfer.
        set_cfg(0, 0, 0, 0, 0, 0);
        tbl[0] = '{1, 0, 0, 4'b0000, 1, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 4'b0001, 1, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 4'b0000, 0, 0, 1, 1};
        tbl[3] = '{0, 0, 0, 4'b0000, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 1, 4'b0001, 0, 0, 0, 1};
        tbl[5] = '{0, 0, 0, 4'b0000, 0, 0, 0, 1};
        tbl[6] = '{0, 1, 0, 4'b0000, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].arm, tbl[i].abort, tbl[i].xfer, tbl[i].hit);
            check($sformatf("table_row%0d", i), dut_status(),
                  pack(tbl[i].e_armed, tbl[i].e_stage, tbl[i].e_trg, tbl[i].e_run));
        end

        // Reset mid-delay discards progress and nothing fires afterwards.
        set_cfg(0, 0, 0, 0, 0, 10);
        step(1'b1, 1'b0, 1'b0, '0);
        hit_pair(4'b0001);
        step(1'b0, 1'b0, 1'b1, 4'b1111);
        check("delay_armed_before_reset", int'(sts_armed), 1);
        do_reset();
        check("reset_mid_delay", dut_status(), 0);
        trg_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'b1111);
            if (sts_trg) trg_cnt++;
        end
        check("no_trg_after_reset", trg_cnt, 0);

        // Occurrence count of 2 needs 3 hits; hits for other stages are ignored.
        set_cfg(0, 2, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, '0);
        hit_pair(4'b0010);
        hit_pair(4'b1110);
        check("other_stage_ignored", int'(sts_trg), 0);
        for (int i = 0; i < 3; i++) begin
            hit_pair(4'b0001);
            check($sformatf("occ_hit%0d_trg", i + 1), int'(sts_trg), (i == 2) ? 1 : 0);
        end

        // Four stages with counts {0,1,0,3}.
        set_cfg(3, 0, 1, 0, 3, 0);
        step(1'b1, 1'b0, 1'b0, '0);
        hit_stage = '{0, 1, 1, 2, 3, 3, 3, 3};
        exp_stage = '{1, 1, 2, 3, 3, 3, 3, 3};
        for (int i = 0; i < 8; i++) begin
            logic [STN-1:0] h;
            h = STN'(1) << hit_stage[i];
            hit_pair(h);
            check($sformatf("four_stage_hit%0d", i), int'(sts_stage), exp_stage[i]);
            check($sformatf("four_stage_trg%0d", i), int'(sts_trg), (i == 7) ? 1 : 0);
        end

        // Delay of 5 transfers with the stream toggling every other cycle.
        set_cfg(0, 0, 0, 0, 0, 5);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 4'b0001);
        trg_at  = -1;
        trg_cnt = 0;
        for (int n = 1; n <= 16; n++) begin
            step(1'b0, 1'b0, (n % 2 == 0), '0);
            if (sts_trg) begin
                trg_cnt++;
                if (trg_at < 0) trg_at = n;
            end
        end
        check("delay_trg_step", trg_at, 11);
        check("delay_trg_pulses", trg_cnt, 1);
        check("delay_run_held", int'(sts_run), 1);

        // Simultaneous arm and abort while matching: abort wins.
        set_cfg(0, 1, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        check("arm_abort_idle", dut_status(), 0);

        // Re-arm from DONE clears run and restarts at stage 0.
        set_cfg(0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, '0);
        hit_pair(4'b0001);
        check("rearm_first_trg", int'(sts_trg), 1);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("rearm_from_done", dut_status(), pack(1, 0, 0, 0));
        hit_pair(4'b0001);
        check("rearm_second_trg", int'(sts_trg), 1);

        // Randomized traffic against the model.
        for (int cfg_i = 0; cfg_i < 4; cfg_i++) begin
            int errs;
            errs = 0;
            set_cfg(int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                    int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                    int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
            do_reset();
            for (int c = 0; c < 300; c++) begin
                bit arm, abort, xfer;
                logic [STN-1:0] h;
                arm   = ($urandom_range(99, 0) < 6);
                abort = ($urandom_range(99, 0) < 2);
                xfer  = $urandom_range(1, 0) == 1;
                h     = STN'($urandom);
                step(arm, abort, xfer, h);
                if (dut_status() != model_status()) errs++;
                if (errs == 1 && dut_status() != model_status()) begin
                    $display("FAIL random cfg%0d cycle %0d: got %0h expected %0h",
                             cfg_i, c, dut_status(), model_status());
                end
            end
            n_checks++;
            if (errs == 0) n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Multi-stage trigger controller that sequences the outputs of STN trigger matcher instances into a single capture trigger. Each stage waits for a configurable number of hits from its own matcher before advancing; after the last stage, a post-trigger delay counted in transfers elapses, then a one-cycle trigger pulse is issued. It sits between the matcher bank and the capture/sampler control in the trigger top level.

## Interface
- STN, 4, number of stages / matcher inputs (2..16)
- CNW, 16, width of occurrence and delay counters
- SNW, $clog2(STN), stage index width (derived, not overridable)

- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- ctl_arm  in  1  single-cycle pulse: start/restart sequence at stage 0
- ctl_abort  in  1  single-cycle pulse: return to idle
- cfg_last  in  SNW  index of final stage (stages above it ignored)
- cfg_cnt  in  STN*CNW  per-stage occurrence count; stage s occupies [s*CNW +: CNW]; stage needs cfg_cnt+1 hits
- cfg_dly  in  CNW  post-trigger delay in transfers
- sti_transfer  in  1  same stream qualifier fed to the matchers
- evt_in  in  STN  sts_evt of matcher s on bit s
- sts_armed  out  1  sequence active (MATCH or DELAY)
- sts_stage  out  SNW  current stage index
- sts_trg  out  1  one-cycle trigger pulse
- sts_run  out  1  high from trigger pulse until re-arm/abort

## Operation
- Matcher sts_evt updates one cycle after its transfer; block registers sti_transfer into evt_vld to align. Events and delay counts are qualified only by evt_vld=1.
- Single CNW-bit counter cnt shared between MATCH and DELAY.
- States: IDLE, MATCH, DELAY, FIRE, DONE.
- IDLE: all status 0. ctl_arm -> MATCH, stage=0, cnt=0.
- MATCH: on evt_vld & evt_in[stage]:
  - cnt != cfg_cnt[stage] -> cnt+1.
  - cnt == cfg_cnt[stage], stage != cfg_last -> stage+1, cnt=0.
  - cnt == cfg_cnt[stage], stage == cfg_last -> cfg_dly==0 ? FIRE : DELAY, cnt=0.
  - evt_in bits of other stages ignored.
- DELAY: on evt_vld, cnt==cfg_dly-1 -> FIRE, else cnt+1.
- FIRE: sts_trg=1 for exactly this cycle -> DONE.
- DONE: sts_run=1, holds until ctl_arm (-> MATCH, stage 0) or ctl_abort (-> IDLE).
- ctl_abort in any state -> IDLE next cycle; wins over simultaneous ctl_arm.
- ctl_arm in MATCH/DELAY/FIRE/DONE restarts at stage 0, cnt=0; a FIRE cycle coinciding with arm still outputs its pulse.
- cfg_* must be static while sts_armed=1; changes are undefined, not checked.
- cfg_last > STN-1 is treated as STN-1.
- Counter cannot overflow: comparison is equality against cfg value at most 2^CNW-1.

## Timing
- Reset (rst=0): state IDLE, cnt=0, stage=0, evt_vld=0; sts_armed=0, sts_stage=0, sts_trg=0, sts_run=0. Reset mid-sequence discards progress.
- All outputs registered; sts_armed high the cycle after ctl_arm.
- Hit transfer at edge k -> matcher sts_evt at k+1 -> sequencer consumes at edge k+1.
- Single stage, cfg_cnt=0, cfg_dly=0: hit transfer at edge k -> FIRE (sts_trg=1) in cycle after edge k+1, i.e. 2 cycles after transfer.
- Each extra delay unit adds one transfer; idle cycles (sti_transfer=0) do not count.
- Back-to-back qualifying events each count (one per cycle max).

## Structure
- trigger_pkg: state enum (IDLE, MATCH, DELAY, FIRE, DONE), default STN/CNW constants, stage-slice helper function for cfg_cnt.
- No sub-module; the STN trigger_matcher instances and this block are instantiated side by side in the trigger top.

## Test plan
- Reset: drive rst=0 mid-DELAY with cfg_dly=10 -> all outputs 0 next cycle, no sts_trg afterwards without new arm.
- Single stage: cfg_last=0, cfg_cnt[0]=0, cfg_dly=0, one hit transfer -> sts_trg one cycle, 2 cycles after transfer; sts_run stays 1.
- Occurrence: cfg_cnt[0]=2 -> trigger only after 3rd hit; hits on evt_in[1] while stage 0 ignored.
- Four stages: cfg_last=3, cfg_cnt={0,1,0,3} -> sts_stage steps 0,1,2,3 after 1,2,1 hits; trigger after 4 stage-3 hits.
- Delay: cfg_dly=5 with sti_transfer toggling every other cycle -> sts_trg after exactly 5 qualified transfers (~10 cycles).
- Arm/abort: simultaneous ctl_arm+ctl_abort in MATCH -> IDLE; ctl_arm in DONE -> sts_run 0, sts_stage 0, sequence restarts.
